// File: rtl/manchester_rxd.sv
// -----------------------------------------------------------------------------
// manchester_rxd
// Manchester (IEEE 802.3 polarity) receive bit-timing and byte assembly.
// The line is oversampled at SPB ticks per bit. The receiver locks to mid-bit
// transitions, samples each bit a quarter bit after its mid-point edge, and
// shifts bits in LSB first. A missing mid-bit edge ends the frame: cleanly
// (eof) on a byte boundary, or with error when a byte is only partly received.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-low reset
//   enb_sample  one-cycle tick at SPB x bit rate; state advances only on ticks
//   rxd         synchronized serial line, idle high
//   data        last completed byte (LSB received first)
//   valid       one-cycle pulse, data has just been updated
//   busy        high while a frame is being received
//   eof         one-cycle pulse, frame ended on a byte boundary
//   error       one-cycle pulse, frame ended mid-byte
// -----------------------------------------------------------------------------
module manchester_rxd #(
    parameter int SPB = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enb_sample,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       eof,
    output logic       error
);

    localparam int CW = $clog2(5*SPB/4+1);

    // Counter values are compared against the tick count after this tick's
    // increment, so "cnt == N" means N ticks have elapsed since the edge.
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(SPB/4);
    localparam logic [CW-1:0] CNT_WIN_LO = CW'(3*SPB/4);
    localparam logic [CW-1:0] CNT_WIN_HI = CW'(5*SPB/4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s, cnt_inc_s;
    logic [2:0]      bitcnt_r, bitcnt_s;
    logic [7:0]      shreg_r, shreg_s, shreg_in_s;
    logic            nbytes_r, nbytes_s;
    logic            rxd_q_r;
    logic            edge_s;
    logic            in_window_s;
    logic [7:0]      data_s;
    logic            valid_s;
    logic            busy_s;
    logic            eof_s;
    logic            error_s;

    // Next-state, counters, shift register and output pulse decode.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        bitcnt_s    = bitcnt_r;
        shreg_s     = shreg_r;
        nbytes_s    = nbytes_r;
        data_s      = data;
        valid_s     = 1'b0;
        eof_s       = 1'b0;
        error_s     = 1'b0;
        cnt_inc_s   = cnt_r + CNT_ONE;
        edge_s      = rxd ^ rxd_q_r;
        in_window_s = (cnt_inc_s >= CNT_WIN_LO) && (cnt_inc_s <= CNT_WIN_HI);
        shreg_in_s  = {rxd, shreg_r[7:1]};

        if (enb_sample) begin
            case (state_r)
                IDLE: begin
                    // A low level out of idle is the sync bit mid-point.
                    if (!rxd) begin
                        state_s  = SYNC;
                        cnt_s    = CNT_ZERO;
                        bitcnt_s = 3'd0;
                        shreg_s  = 8'd0;
                        nbytes_s = 1'b0;
                    end else begin
                        state_s  = IDLE;
                    end
                end

                SYNC: begin
                    cnt_s = cnt_inc_s;
                    // A real sync bit is still low a quarter bit later.
                    if (cnt_inc_s == CNT_SAMPLE) begin
                        if (rxd) begin
                            state_s = IDLE;
                        end else begin
                            state_s = DATA;
                        end
                    end else begin
                        state_s = SYNC;
                    end
                end

                DATA: begin
                    cnt_s = cnt_inc_s;
                    if (cnt_inc_s == CNT_SAMPLE) begin
                        shreg_s = shreg_in_s;
                        if (bitcnt_r == 3'd7) begin
                            data_s   = shreg_in_s;
                            valid_s  = 1'b1;
                            bitcnt_s = 3'd0;
                            nbytes_s = 1'b1;
                        end else begin
                            bitcnt_s = bitcnt_r + 3'd1;
                        end
                    end else if (edge_s && in_window_s) begin
                        // Mid-bit edge: realign. Bit-boundary edges near
                        // SPB/2 fall outside the window and are ignored.
                        cnt_s = CNT_ZERO;
                    end else if (cnt_inc_s == CNT_WIN_HI) begin
                        state_s = IDLE;
                        cnt_s   = CNT_ZERO;
                        if (bitcnt_r != 3'd0) begin
                            error_s  = 1'b1;
                            shreg_s  = 8'd0;
                            bitcnt_s = 3'd0;
                        end else begin
                            eof_s    = nbytes_r;
                        end
                    end else begin
                        state_s = DATA;
                    end
                end

                default: begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        busy_s = (state_s != IDLE);
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            bitcnt_r <= 3'd0;
            shreg_r  <= 8'd0;
            nbytes_r <= 1'b0;
            rxd_q_r  <= 1'b1;
            data     <= 8'd0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            eof      <= 1'b0;
            error    <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            bitcnt_r <= bitcnt_s;
            shreg_r  <= shreg_s;
            nbytes_r <= nbytes_s;
            data     <= data_s;
            valid    <= valid_s;
            busy     <= busy_s;
            eof      <= eof_s;
            error    <= error_s;
            if (enb_sample) begin
                rxd_q_r <= rxd;
            end
        end
    end

endmodule

// File: tb/tb_manchester_rxd.sv
// -----------------------------------------------------------------------------
// tb_manchester_rxd
// Table-driven bench for manchester_rxd (SPB=16, one tick every 4 clocks).
// Each vector describes a frame (payload bits, count, mid-bit timing mode) and
// the pulses/data expected from it; a waveform is built per vector and played.
// Hand-written sequences cover the sync glitch and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_manchester_rxd;

    localparam int SPB = 16;
    localparam int PRE = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       enb_sample;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       eof;
    logic       error;

    manchester_rxd #(.SPB(SPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .enb_sample (enb_sample),
        .rxd        (rxd),
        .data       (data),
        .valid      (valid),
        .busy       (busy),
        .eof        (eof),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] pat;       // payload bits, LSB sent first
        int          nbits;     // payload bits sent after the sync bit
        int          mode;      // 0 nominal, 1 +/-3 jitter, 2 one edge at 21
        int          exp_valid;
        logic [7:0]  exp_first;
        logic [7:0]  exp_data;
        int          exp_eof;
        int          exp_err;
    } vec_t;

    vec_t vecs [5];

    int n_checks = 0;
    int n_errors = 0;

    // Pulse monitor (sole writer of these counters)
    int         n_valid  = 0;
    int         n_eof    = 0;
    int         n_err    = 0;
    int         eof_tick = -1;
    logic [7:0] dlog [$];

    int   tick_no    = 0;
    int   cur_tick   = 0;
    int   busy_ticks = 0;
    logic wave [$];
    int   last_idx;

    // Count output pulses away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            dlog.push_back(data);
        end
        if (eof) begin
            n_eof++;
            eof_tick = cur_tick;
        end
        if (error) begin
            n_err++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One sample tick: enb_sample high for one clock, then three idle clocks.
    task automatic do_tick(input logic r);
        @(negedge clk);
        rxd        = r;
        enb_sample = 1'b1;
        cur_tick   = tick_no;
        tick_no++;
        @(negedge clk);
        enb_sample = 1'b0;
        if (busy) busy_ticks++;
        @(negedge clk);
        @(negedge clk);
    endtask

    function automatic int interval(input int k, input int mode);
        int v;
        v = SPB;
        if (mode == 1) v = (k % 2 == 1) ? SPB + 3 : SPB - 3;
        if (mode == 2 && k == 3) v = 21;
        return v;
    endfunction

    // Build a line waveform: idle, sync '0', payload bits, idle.
    // last_idx is the wave index of the final mid-bit edge.
    task automatic build(input logic [15:0] pat, input int nbits, input int mode);
        logic b [0:16];
        int   len;
        int   h;
        int   idx;
        wave.delete();
        b[0] = 1'b0;
        for (int k = 1; k <= 16; k++) b[k] = (k <= nbits) ? pat[k-1] : 1'b0;
        for (int i = 0; i < PRE; i++) wave.push_back(1'b1);
        idx = PRE;
        for (int k = 0; k < nbits; k++) begin
            len = interval(k + 1, mode);
            h   = len / 2;
            for (int i = 0; i < h; i++) wave.push_back(b[k]);
            for (int i = 0; i < len - h; i++) wave.push_back(~b[k+1]);
            idx += len;
        end
        last_idx = idx;
        for (int i = 0; i < SPB/2; i++) wave.push_back(b[nbits]);
        for (int i = 0; i < 40; i++) wave.push_back(1'b1);
    endtask

    task automatic play(output int base);
        base = tick_no;
        foreach (wave[i]) do_tick(wave[i]);
    endtask

    int bv, be, br, bd, base;

    initial begin
        vecs[0] = '{"a5",    16'h00A5, 8,  0, 1, 8'hA5, 8'hA5, 1, 0};
        vecs[1] = '{"00ff",  16'hFF00, 16, 0, 2, 8'h00, 8'hFF, 1, 0};
        vecs[2] = '{"bits3", 16'h0005, 3,  0, 0, 8'h00, 8'hFF, 0, 1};
        vecs[3] = '{"jit3c", 16'h003C, 8,  1, 1, 8'h3C, 8'h3C, 1, 0};
        vecs[4] = '{"late",  16'h003C, 3,  2, 0, 8'h00, 8'h3C, 0, 1};

        reset      = 1'b0;
        enb_sample = 1'b0;
        rxd        = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data",  int'(data),  0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy",  int'(busy),  0);
        chk("rst_eof",   int'(eof),   0);
        chk("rst_error", int'(error), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            bv = n_valid; be = n_eof; br = n_err; bd = dlog.size();
            build(vecs[v].pat, vecs[v].nbits, vecs[v].mode);
            play(base);
            chk($sformatf("%s_valid", vecs[v].name), n_valid - bv, vecs[v].exp_valid);
            if (vecs[v].exp_valid > 0 && dlog.size() > bd)
                chk($sformatf("%s_first", vecs[v].name), int'(dlog[bd]), int'(vecs[v].exp_first));
            chk($sformatf("%s_data", vecs[v].name), int'(data), int'(vecs[v].exp_data));
            chk($sformatf("%s_eof", vecs[v].name), n_eof - be, vecs[v].exp_eof);
            chk($sformatf("%s_err", vecs[v].name), n_err - br, vecs[v].exp_err);
            chk($sformatf("%s_busy", vecs[v].name), int'(busy), 0);
            if (vecs[v].exp_eof > 0)
                chk($sformatf("%s_eoflat", vecs[v].name), eof_tick, base + last_idx + 20);
        end

        // Sync glitch: one low tick out of idle.
        bv = n_valid; be = n_eof; br = n_err;
        busy_ticks = 0;
        wave.delete();
        for (int i = 0; i < 5; i++) wave.push_back(1'b1);
        wave.push_back(1'b0);
        for (int i = 0; i < 20; i++) wave.push_back(1'b1);
        play(base);
        chk("glitch_busy_ticks", busy_ticks, 4);
        chk("glitch_pulses", (n_valid - bv) + (n_eof - be) + (n_err - br), 0);
        chk("glitch_busy_end", int'(busy), 0);

        // Reset asserted after four data bits of a frame.
        bv = n_valid; be = n_eof; br = n_err;
        build(16'h00FF, 8, 0);
        for (int i = 0; i < PRE + 4*SPB + 6; i++) do_tick(wave[i]);
        chk("mid_busy", int'(busy), 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_data",  int'(data),  0);
        chk("mrst_valid", int'(valid), 0);
        chk("mrst_busy",  int'(busy),  0);
        chk("mrst_eof",   int'(eof),   0);
        chk("mrst_error", int'(error), 0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) do_tick(1'b1);
        build(16'h0081, 8, 0);
        play(base);
        chk("post_valid", n_valid - bv, 1);
        chk("post_data",  int'(data), 8'h81);
        chk("post_eof",   n_eof - be, 1);
        chk("post_err",   n_err - br, 0);
        chk("post_eoflat", eof_tick, base + last_idx + 20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/manchester_rxd.md
Name: manchester_rxd

Overview:
- Receive-side counterpart of the WimpFi Manchester transmitter bit-timing logic.
- Oversamples the synchronized serial line, locks to mid-bit transitions, shifts in bits LSB-first and emits one byte per 8 bits.
- Flags end-of-frame on line timeout at a byte boundary, and flags an error on timeout mid-byte.
- Sits between the rxd input synchronizer and the frame/FIFO logic.

Parameters:
- SPB, 16: enb_sample ticks per bit period. Multiple of 4, ≥8.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- enb_sample  input  1  single-cycle tick at SPB × bit rate; all state advances only on ticks
- rxd  input  1  serial line, already synchronized upstream; idle high
- data  output  8  last received byte; LSB received first
- valid  output  1  one-cycle pulse; data is new
- busy  output  1  high while not in IDLE
- eof  output  1  one-cycle pulse; frame ended cleanly
- error  output  1  one-cycle pulse; frame ended mid-byte

Behaviour:
- Encoding (IEEE 802.3 convention):
  - '0' is high then low; '1' is low then high.
  - Bit value equals the line level in the second half of the bit.
- Frame format: idle high, then one sync '0' bit, then N≥0 bytes, then idle high.
- Reset (reset==0 at posedge clk):
  - state=IDLE; cnt, bitcnt, shreg, nbytes cleared.
  - data=0, valid=0, busy=0, eof=0, error=0.
  - Applies mid-frame with no pulse emitted.
- rxd_q holds the rxd value from the previous tick and updates on every tick. A tick-level edge is rxd != rxd_q.
- cnt counts ticks since the last accepted mid-bit edge. Width is $clog2(5*SPB/4+1).
- States:
  - IDLE: on a tick with rxd==0, go to SYNC with cnt=0. This falling edge is taken as the sync bit mid-point.
  - SYNC: cnt++ each tick. At cnt==SPB/4:
    - rxd==1 (glitch): go to IDLE silently, no pulses.
    - rxd==0: go to DATA, keep counting.
  - DATA, bit sampling: at cnt==SPB/4 of every data bit, shreg={rxd,shreg[7:1]} and bitcnt++.
  - DATA, byte complete: when bitcnt reaches 8:
    - data is loaded from the completed shreg.
    - valid pulses high for exactly one clk, in the cycle after that tick.
    - bitcnt=0; nbytes++, saturating at 1 (only "≥1 byte" is tracked).
  - Resync window: cnt in [3*SPB/4, 5*SPB/4]. An edge in the window is the next mid-bit; set cnt=0.
    - Edges outside the window are ignored. This covers boundary transitions at cnt≈SPB/2.
    - An edge at cnt==5*SPB/4 is still accepted; the edge check has priority over timeout.
  - Timeout: on the tick where cnt==5*SPB/4 and there is no edge, go to IDLE and:
    - bitcnt==0 and nbytes≥1: eof pulse (1 clk).
    - bitcnt==0 and nbytes==0: no pulse.
    - bitcnt≠0: error pulse (1 clk); shreg is discarded and data is unchanged.
  - The sync bit's mid-point counts as the first mid-bit, so the window and timeout rules also apply after SYNC.
- Timing:
  - The edge at the first data bit's mid-point is required at cnt in [3SPB/4, 5SPB/4] after the sync edge.
  - Tolerated mid-bit jitter is ±SPB/4 ticks.
- busy=1 in SYNC/DATA, 0 in IDLE.
- eof/error fire in the cycle after the timeout tick, coincident with busy falling.
- valid and error never fire for the same byte.
- No action on cycles with enb_sample==0, except that output pulses clear.

Test Plan (SPB=16, one enb_sample every 4 clks):
- Sync '0' + byte 0xA5 + idle → valid once with data=0xA5, then eof exactly 20 ticks after the last mid-bit edge; error never asserts.
- Sync + 0x00 + 0xFF back-to-back (boundary edges every bit) → valid twice with data 0x00 then 0xFF, then one eof.
- Sync + 3 bits of 0x05 then idle → error pulse at timeout; no valid; data keeps its prior value; busy drops.
- Idle with rxd low for 1 tick only → no valid/eof/error; busy high for 4 ticks then IDLE.
- Byte 0x3C with each mid-bit edge shifted ±3 ticks → data=0x3C. Separately, one edge delayed to cnt=21 → error pulse.
- reset=0 asserted mid-byte (after 4 bits) → all outputs 0 next cycle. A following full frame with 0x81 decodes to data=0x81 plus eof.
